trace_stream_arbiter: RTL and testbench

//  Shares one cpu_checker instance between NSRC trace-text sources. Grants one

---
 rtl/trace_stream_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_trace_stream_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_arbiter.sv
// ============================================================================
// trace_stream_arbiter : round-robin sharing of one cpu_checker by NSRC sources
// Revision 1.0
// ============================================================================
`default_nettype none

module trace_stream_arbiter #(
    parameter int NSRC        = 2,
    parameter int SRC_W       = 1,
    parameter int MAX_LEN     = 64,
    parameter int VERDICT_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NSRC-1:0]     src_valid,
    input  logic [NSRC*8-1:0]   src_char,
    output logic [NSRC-1:0]     src_ready,
    output logic [7:0]          chk_char,
    input  logic [1:0]          chk_format_type,
    output logic                res_valid,
    output logic [SRC_W-1:0]    res_src,
    output logic [1:0]          res_type,
    output logic                res_abort,
    output logic                busy
);

    localparam int         LEN_W    = $clog2(MAX_LEN + 1);
    localparam int         CNT_W    = $clog2(VERDICT_LAT + 2);
    localparam logic [7:0] CHAR_SOP = 8'h5E;
    localparam logic [7:0] CHAR_EOP = 8'h23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   rr_q, rr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         chk_char_q, chk_char_d;
    logic               res_valid_q, res_valid_d;
    logic [SRC_W-1:0]   res_src_q, res_src_d;
    logic [1:0]         res_type_q, res_type_d;
    logic               res_abort_q, res_abort_d;

    logic               sel_valid;
    logic [7:0]         sel_char;
    logic [SRC_W:0]     scan;
    logic               abort;

    // First requester at or after ptr (wrapping); MSB flags that one was found.
    function automatic logic [SRC_W:0] rr_scan(input logic [NSRC-1:0] v,
                                               input logic [SRC_W-1:0] ptr);
        logic [SRC_W:0] r;
        int             idx;
        r = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (v[idx]) r = {1'b1, SRC_W'(idx)};
        end
        return r;
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_char  = 8'h00;
        src_ready = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant_q == SRC_W'(i)) begin
                sel_valid    = src_valid[i];
                sel_char     = src_char[i*8 +: 8];
                src_ready[i] = (state_q == STREAM);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        chk_char_d  = 8'h00;
        res_src_d   = res_src_q;
        res_type_d  = res_type_q;
        res_abort_d = res_abort_q;
        abort       = 1'b0;
        scan        = rr_scan(src_valid, rr_q);

        case (state_q)
            IDLE: begin
                if (scan[SRC_W]) begin
                    grant_d = scan[SRC_W-1:0];
                    len_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // A stall would leave a bubble inside the checker's parse.
                if (!sel_valid || (len_q == '0 && sel_char != CHAR_SOP)) begin
                    abort = 1'b1;
                end else begin
                    len_d = len_q + LEN_W'(1);
                    if (sel_char == CHAR_EOP) begin
                        chk_char_d = sel_char;
                        cnt_d      = '0;
                        state_d    = WAIT;
                    end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
                        abort = 1'b1;
                    end else begin
                        chk_char_d = sel_char;
                    end
                end
                if (abort) begin
                    state_d     = REPORT;
                    res_src_d   = grant_q;
                    res_type_d  = 2'b00;
                    res_abort_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(VERDICT_LAT)) begin
                    state_d     = REPORT;
                    res_src_d   = grant_q;
                    res_type_d  = chk_format_type;
                    res_abort_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPORT: begin
                rr_d    = (grant_q == SRC_W'(NSRC - 1)) ? '0 : grant_q + SRC_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        res_valid_d = (state_d == REPORT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            chk_char_q  <= 8'h00;
            res_valid_q <= 1'b0;
            res_src_q   <= '0;
            res_type_q  <= 2'b00;
            res_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            chk_char_q  <= chk_char_d;
            res_valid_q <= res_valid_d;
            res_src_q   <= res_src_d;
            res_type_q  <= res_type_d;
            res_abort_q <= res_abort_d;
        end
    end

    assign chk_char  = chk_char_q;
    assign res_valid = res_valid_q;
    assign res_src   = res_src_q;
    assign res_type  = res_type_q;
    assign res_abort = res_abort_q;
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_trace_stream_arbiter.sv
// ============================================================================
// tb_trace_stream_arbiter : scoreboard bench for trace_stream_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_trace_stream_arbiter;

    localparam int NSRC        = 2;
    localparam int SRC_W       = 1;
    localparam int MAX_LEN     = 64;
    localparam int VERDICT_LAT = 1;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NSRC-1:0]     src_valid;
    logic [NSRC*8-1:0]   src_char;
    logic [NSRC-1:0]     src_ready;
    logic [7:0]          chk_char;
    logic [1:0]          fmt;
    logic                res_valid;
    logic [SRC_W-1:0]    res_src;
    logic [1:0]          res_type;
    logic                res_abort;
    logic                busy;

    logic                val [NSRC];
    logic [7:0]          chv [NSRC];
    logic [1:0]          stub_type = 2'b00;

    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [1:0]       typ;
        logic             ab;
    } verdict_t;

    logic [7:0] exp_c [$];
    verdict_t   exp_v [$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [7:0] mon_e;
    verdict_t   mon_v;

    always #5 clk = ~clk;

    always_comb begin
        src_valid = '0;
        src_char  = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_valid[i]        = val[i];
            src_char[i*8 +: 8]  = chv[i];
        end
    end

    trace_stream_arbiter #(
        .NSRC(NSRC), .SRC_W(SRC_W), .MAX_LEN(MAX_LEN), .VERDICT_LAT(VERDICT_LAT)
    ) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_char(src_char),
        .src_ready(src_ready), .chk_char(chk_char), .chk_format_type(fmt),
        .res_valid(res_valid), .res_src(res_src), .res_type(res_type),
        .res_abort(res_abort), .busy(busy)
    );

    // Checker stub: format_type pulses one cycle after '#' shows on chk_char.
    always @(posedge clk or negedge reset) begin
        if (!reset) fmt <= 2'b00;
        else        fmt <= (chk_char == 8'h23) ? stub_type : 2'b00;
    end

    // chk_char must equal the char accepted on the previous edge, else 0.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            mon_e = (exp_c.size() > 0) ? exp_c.pop_front() : 8'h00;
            checks++;
            if (chk_char !== mon_e) begin
                errors++;
                $display("FAIL chk_char t=%0t actual=%h expected=%h", $time, chk_char, mon_e);
            end
            if (res_valid === 1'b1) begin
                checks++;
                if (exp_v.size() == 0) begin
                    errors++;
                    $display("FAIL res_valid_unexpected t=%0t actual=1 expected=0", $time);
                end else begin
                    mon_v = exp_v.pop_front();
                    if ({res_src, res_type, res_abort} !== mon_v) begin
                        errors++;
                        $display("FAIL verdict t=%0t actual src=%0d type=%b abort=%b expected src=%0d type=%b abort=%b",
                                 $time, res_src, res_type, res_abort, mon_v.src, mon_v.typ, mon_v.ab);
                    end
                end
            end
        end
    end

    task automatic send(input int s, input string msg, input int n_fwd,
                        input int max_acc, input bit drop);
        int i = 0;
        int budget = 0;
        bit acc;
        while (i < msg.len() && i < max_acc && budget < 1000) begin
            @(negedge clk);
            val[s] = 1'b1;
            chv[s] = msg[i];
            #1 acc = src_ready[s];
            @(posedge clk);
            if (acc) begin
                if (i < n_fwd) exp_c.push_back(msg[i]);
                i++;
            end
            budget++;
        end
        if (budget >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout src=%0d accepted=%0d expected=%0d", s, i, msg.len());
        end
        if (drop) begin
            @(negedge clk);
            val[s] = 1'b0;
            chv[s] = 8'h00;
        end
    endtask

    task automatic push_v(input int s, input logic [1:0] t, input logic ab);
        verdict_t v;
        v.src = SRC_W'(s);
        v.typ = t;
        v.ab  = ab;
        exp_v.push_back(v);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && exp_v.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_v.size() != 0) begin
            errors++;
            $display("FAIL verdict_timeout pending=%0d expected=0", exp_v.size());
            exp_v.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (chk_char !== 8'h00 || src_ready !== '0 || res_valid !== 1'b0 ||
            res_src !== '0 || res_type !== 2'b00 || res_abort !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s actual chk=%h rdy=%b rv=%b src=%0d type=%b ab=%b busy=%b expected all 0",
                     tag, chk_char, src_ready, res_valid, res_src, res_type, res_abort, busy);
        end
    endtask

    task automatic test_reset();
        #2 check_reset_outputs("reset_state");
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        stub_type = 2'b01;
        push_v(0, 2'b01, 1'b0);
        push_v(1, 2'b01, 1'b0);
        fork
            send(0, "^338@00001000: $ 1 <= 00000001#", 1000, 1000, 1'b1);
            send(1, "^338@00002000: *00000010 <= 0000abcd#", 1000, 1000, 1'b1);
        join
        wait_done();
        stub_type = 2'b11;
        push_v(0, 2'b11, 1'b0);
        push_v(1, 2'b11, 1'b0);
        fork
            send(0, "^1@2: $3 <= 4#", 1000, 1000, 1'b1);
            send(1, "^9@8: *7 <= 6#", 1000, 1000, 1'b1);
        join
        wait_done();
    endtask

    task automatic test_single();
        stub_type = 2'b10;
        push_v(0, 2'b10, 1'b0);
        send(0, "^338@00003130: *00000088 <= fffb528#", 1000, 1000, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_wait actual=%b expected=1", busy);
        end
        wait_done();
    endtask

    task automatic test_stall();
        stub_type = 2'b10;
        push_v(1, 2'b00, 1'b1);
        send(1, "^338@00003130: *00000088 <= fffb528#", 5, 5, 1'b1);
        wait_done();
    endtask

    task automatic test_max_len();
        string m;
        stub_type = 2'b11;
        m = "^";
        for (int i = 0; i < MAX_LEN - 2; i++) m = {m, "A"};
        m = {m, "#"};
        push_v(0, 2'b11, 1'b0);
        send(0, m, 1000, 1000, 1'b1);
        wait_done();
        m = "^";
        for (int i = 0; i < MAX_LEN - 1; i++) m = {m, "A"};
        push_v(0, 2'b00, 1'b1);
        send(0, m, MAX_LEN - 1, MAX_LEN, 1'b1);
        wait_done();
    endtask

    task automatic test_bad_start();
        stub_type = 2'b01;
        push_v(0, 2'b00, 1'b1);
        send(0, "3^#", 0, 1, 1'b1);
        wait_done();
    endtask

    task automatic test_reset_mid_message();
        send(1, "^338@00003130#", 1000, 5, 1'b0);
        checks++;
        if (busy !== 1'b1 || chk_char === 8'h00) begin
            errors++;
            $display("FAIL pre_reset_busy actual busy=%b chk=%h expected busy=1 chk!=0", busy, chk_char);
        end
        #3 reset = 1'b0;
        exp_c.delete();
        #1 check_reset_outputs("async_reset");
        val[1] = 1'b0;
        chv[1] = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        stub_type = 2'b10;
        push_v(0, 2'b10, 1'b0);
        push_v(1, 2'b10, 1'b0);
        fork
            send(0, "^5@6: $7 <= 8#", 1000, 1000, 1'b1);
            send(1, "^4@3: $2 <= 1#", 1000, 1000, 1'b1);
        join
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < NSRC; i++) begin
            val[i] = 1'b0;
            chv[i] = 8'h00;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_max_len();
        test_bad_start();
        test_reset_mid_message();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
